// File: rtl/apb_mem_bridge.sv
// ============================================================================
// apb_mem_bridge : APB3/APB4 completer driving a single-strobe memory request bus
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_mem_bridge #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h5F),
   parameter int                TIMEOUT    = 16
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W/8-1:0] pstrb,
   output logic [DATA_W-1:0]   prdata,
   output logic                pready,
   output logic                pslverr,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic                mem_we,
   output logic                mem_re,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready,
   output logic                proto_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

   state_t      state;
   logic        wr;
   logic        ign_seen;
   logic [7:0]  cnt;
   logic [7:0]  cnt_inc;
   logic        bad_addr;
   logic        access;

   assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   assign bad_addr = (paddr[1:0] != 2'b00) || (paddr > ADDR_LIMIT);
   assign access   = psel && penable;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         wr        <= 1'b0;
         ign_seen  <= 1'b0;
         cnt       <= 8'd0;
         prdata    <= '0;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         // Strobes and the response are single-cycle pulses by default.
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
         proto_err <= 1'b0;
         case (state)
            IDLE: begin
               ign_seen <= access;
               if (psel && !penable) begin
                  wr <= pwrite;
                  if (bad_addr) begin
                     state   <= RESP;
                     pready  <= 1'b1;
                     pslverr <= 1'b1;
                     prdata  <= '0;
                  end else begin
                     state     <= REQ;
                     mem_addr  <= paddr;
                     mem_wdata <= pwdata;
                     mem_wstrb <= pwrite ? pstrb : '0;
                     mem_we    <= pwrite;
                     mem_re    <= !pwrite;
                  end
               end else if (access && !ign_seen) begin
                  proto_err <= 1'b1;
               end
            end
            REQ: begin
               cnt <= 8'd0;
               if (!access) begin
                  state     <= IDLE;
                  proto_err <= 1'b1;
                  ign_seen  <= 1'b1;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (!access) begin
                  state     <= IDLE;
                  proto_err <= 1'b1;
                  ign_seen  <= 1'b1;
                  cnt       <= 8'd0;
               end else if (mem_ready) begin
                  state   <= RESP;
                  pready  <= 1'b1;
                  prdata  <= wr ? '0 : mem_rdata;
                  cnt     <= 8'd0;
               end else if (cnt_inc >= TO_LIM) begin
                  state   <= RESP;
                  pready  <= 1'b1;
                  pslverr <= 1'b1;
                  prdata  <= '0;
                  cnt     <= 8'd0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            RESP: begin
               // The master holds the access phase across this edge, so it
               // must not count as a lingering IDLE access afterwards.
               state    <= IDLE;
               cnt      <= 8'd0;
               ign_seen <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_apb_mem_bridge.sv
// ============================================================================
// tb_apb_mem_bridge : directed + randomized self-checking bench for apb_mem_bridge
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_mem_bridge;

   localparam logic [31:0] LIMIT = 32'h5F;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_we, mem_re;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        proto_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   apb_mem_bridge #(
      .ADDR_W(32), .DATA_W(32), .ADDR_LIMIT(LIMIT), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_b(rst_b),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .proto_err(proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete APB transfer. d = cycles after the strobe at which mem_ready
   // pulses for one cycle (0 = on the strobe cycle itself, i.e. ignored).
   task automatic xfer(input string tag, input logic [31:0] a, input bit w,
                       input logic [31:0] wd, input logic [3:0] st,
                       input int d, input logic [31:0] rd);
      int          lat = -1, we_n = 0, re_n = 0, st_cyc = -1, pe_n = 0;
      logic [31:0] s_addr = '0, s_wd = '0, s_pr = '0;
      logic [3:0]  s_st = '0;
      logic        s_err = 1'b0;
      bit          addr_bad, ok;
      int          e_lat;
      addr_bad = (a[1:0] != 2'b00) || (a > LIMIT);
      ok       = !addr_bad && d >= 1 && d <= 16;
      e_lat    = addr_bad ? 1 : (ok ? 2 + d : 18);

      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a;
      pwdata = wd; pstrb = st; mem_rdata = rd; mem_ready = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         penable = 1'b1;
         if (mem_we || mem_re) begin
            if (mem_we) we_n++;
            if (mem_re) re_n++;
            st_cyc = c; s_addr = mem_addr; s_wd = mem_wdata; s_st = mem_wstrb;
         end
         if (proto_err) pe_n++;
         mem_ready = (c == 1 + d);
         if (pready) begin
            lat = c; s_pr = prdata; s_err = pslverr;
            break;
         end
      end
      mem_ready = 1'b0;
      @(negedge clk);
      chk({tag, ".pready_pulse"}, {31'b0, pready}, 32'd0);
      psel = 1'b0; penable = 1'b0;

      chk({tag, ".latency"}, lat, e_lat);
      chk({tag, ".pslverr"}, {31'b0, s_err}, {31'b0, !ok});
      chk({tag, ".prdata"}, s_pr, (ok && !w) ? rd : 32'd0);
      chk({tag, ".we_count"}, we_n, (!addr_bad && w) ? 1 : 0);
      chk({tag, ".re_count"}, re_n, (!addr_bad && !w) ? 1 : 0);
      chk({tag, ".proto_err"}, pe_n, 0);
      if (!addr_bad) begin
         chk({tag, ".strobe_cycle"}, st_cyc, 1);
         chk({tag, ".mem_addr"}, s_addr, a);
         chk({tag, ".mem_wdata"}, s_wd, wd);
         chk({tag, ".mem_wstrb"}, {28'b0, s_st}, w ? {28'b0, st} : 32'd0);
      end
   endtask

   initial begin
      int n_pe, n_pr, n_st;
      logic [31:0] a;
      rst_b = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; mem_rdata = '0; mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.pready", {31'b0, pready}, 32'd0);
      chk("rst.prdata", prdata, 32'd0);
      chk("rst.mem_addr", mem_addr, 32'd0);
      chk("rst.strobes", {30'b0, mem_we, mem_re}, 32'd0);
      chk("rst.proto_err", {31'b0, proto_err}, 32'd0);
      rst_b = 1'b1;
      @(negedge clk);

      xfer("wr0",  32'h0,  1'b1, 32'h12345678, 4'hF, 1, $urandom);
      xfer("rd8",  32'h8,  1'b0, $urandom, 4'h3, 3, 32'h00200010);
      xfer("to40", 32'h40, 1'b0, $urandom, 4'hF, 99, 32'hDEADBEEF);
      xfer("mis2", 32'h2,  1'b1, 32'hA5A5A5A5, 4'hF, 1, $urandom);
      xfer("oor60", 32'h60, 1'b0, $urandom, 4'hF, 1, 32'h11111111);
      xfer("edge5c", 32'h5C, 1'b0, $urandom, 4'hF, 16, 32'hCAFEF00D);
      xfer("rdy_on_strobe", 32'h14, 1'b0, $urandom, 4'hF, 0, 32'h77777777);

      // Access phase abandoned while waiting for the downstream block.
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4; mem_ready = 1'b0;
      @(negedge clk); penable = 1'b1;
      @(negedge clk);
      @(negedge clk); psel = 1'b0; penable = 1'b0;
      n_pe = 0; n_pr = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (proto_err) n_pe++;
         if (pready) n_pr++;
      end
      chk("abort.proto_err", n_pe, 1);
      chk("abort.pready", n_pr, 0);
      xfer("after_abort", 32'h0, 1'b1, 32'h0BADCAFE, 4'h5, 1, $urandom);

      // Access phase without a setup phase while idle.
      @(negedge clk);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0;
      n_pe = 0; n_pr = 0; n_st = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (proto_err) n_pe++;
         if (pready) n_pr++;
         if (mem_we || mem_re) n_st++;
      end
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk("idle_access.proto_err", n_pe, 1);
      chk("idle_access.pready", n_pr, 0);
      chk("idle_access.strobes", n_st, 0);

      // Reset in the middle of a write, with stale nonzero read data present.
      xfer("pre_rst_rd", 32'h10, 1'b0, $urandom, 4'hF, 2, 32'h5A5A0001);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC;
      pwdata = 32'h87654321; pstrb = 4'hF;
      @(negedge clk); penable = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("midrst.pready", {31'b0, pready}, 32'd0);
      chk("midrst.pslverr", {31'b0, pslverr}, 32'd0);
      chk("midrst.strobes", {30'b0, mem_we, mem_re}, 32'd0);
      chk("midrst.prdata", prdata, 32'd0);
      chk("midrst.mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      xfer("post_rst_rd", 32'h0, 1'b0, $urandom, 4'hF, 1, 32'h13579BDF);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    a = {$urandom_range(0, 23), 2'b00};
            2:       a = {$urandom_range(0, 23), 2'b00} | 32'($urandom_range(1, 3));
            default: a = $urandom_range(32'h60, 32'h200);
         endcase
         xfer($sformatf("rnd%0d", i), a, 1'($urandom_range(0, 1)), $urandom,
              4'($urandom), $urandom_range(0, 18), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
